// File: rtl/regfile_32x64.sv
// 32 x WIDTH architectural register file: one write port, two combinational read ports with write-through bypass.
// Write latency 1 cycle, read latency 0; no backpressure, a write is accepted every cycle it is requested.

module mux32_1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module regfile_32x64 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [31:0][WIDTH-1:0] row;
  logic [WIDTH-1:0]       mux1_dat;
  logic [WIDTH-1:0]       mux2_dat;
  logic                   byp1;
  logic                   byp2;

  // Each row decodes its own enable; the zero row has no storage at all.
  for (genvar r = 0; r < 32; r++) begin : g_row
    if (r == ZERO_REG) begin : g_zero
      assign row[r] = '0;
    end else begin : g_store
      logic             wr_en;
      logic [WIDTH-1:0] q;

      assign wr_en = RegWrite && (WriteRegister == 5'(r));

      always_ff @(posedge clk) begin
        if (!reset) begin
          q <= '0;
        end else if (wr_en) begin
          q <= WriteData;
        end
      end

      assign row[r] = q;
    end
  end

  // Bit-sliced read: slice b selects bit b across all 32 rows.
  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    logic [31:0] col;

    for (genvar r = 0; r < 32; r++) begin : g_col
      assign col[r] = row[r][b];
    end

    mux32_1 u_mux_p1 (
      .d   (col),
      .sel (ReadRegister1),
      .y   (mux1_dat[b])
    );

    mux32_1 u_mux_p2 (
      .d   (col),
      .sel (ReadRegister2),
      .y   (mux2_dat[b])
    );
  end

  // Same-cycle forwarding of the write, held off while reset is asserted.
  assign byp1 = RegWrite && reset && (WriteRegister == ReadRegister1)
                && (ReadRegister1 != 5'(ZERO_REG));
  assign byp2 = RegWrite && reset && (WriteRegister == ReadRegister2)
                && (ReadRegister2 != 5'(ZERO_REG));

  assign ReadData1 = byp1 ? WriteData : mux1_dat;
  assign ReadData2 = byp2 ? WriteData : mux2_dat;

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64: reset, write/read sweep, zero register, bypass, write disable, reset mid-operation.
module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  always #5 clk = ~clk;

  regfile_32x64 #(.WIDTH(64), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset held two edges against a competing write to X5.
    reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hFFFF;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd0;
    tick();
    #1 check("rst_cycle_x5_nobypass", ReadData1, 64'h0);
    tick();
    reset = 1'b1; RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      check($sformatf("rst_sweep_p1_r%0d", i), ReadData1, 64'h0);
      check($sformatf("rst_sweep_p2_r%0d", 31 - i), ReadData2, 64'h0);
    end
    ReadRegister1 = 5'd5;
    #1 check("rst_x5_dropped", ReadData1, 64'h0);

    // 2. Write X0..X30 with i * 0x0101..., read back on both ports.
    tick();
    RegWrite = 1'b1;
    for (int i = 0; i < 31; i++) begin
      WriteRegister = 5'(i); WriteData = 64'(i) * STEP;
      tick();
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(30 - i);
      #1;
      check($sformatf("wr_sweep_p1_r%0d", i), ReadData1, 64'(i) * STEP);
      check($sformatf("wr_sweep_p2_r%0d", 30 - i), ReadData2, 64'(30 - i) * STEP);
    end
    ReadRegister1 = 5'd30;
    #1 check("x30_value", ReadData1, 64'h1E1E_1E1E_1E1E_1E1E);

    // 3. Write to XZR: same-cycle and next-cycle reads stay 0, others intact.
    tick();
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hDEAD_BEEF_0000_0001;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #1;
    check("xzr_same_cycle_p1", ReadData1, 64'h0);
    check("xzr_same_cycle_p2", ReadData2, 64'h0);
    tick();
    RegWrite = 1'b0;
    #1 check("xzr_next_cycle", ReadData1, 64'h0);
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i);
      #1 check($sformatf("xzr_no_side_r%0d", i), ReadData1, 64'(i) * STEP);
    end

    // 4. Bypass on both ports while overwriting X7.
    tick();
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1111;
    tick();
    WriteData = 64'h2222; ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
    #1;
    check("bypass_p1", ReadData1, 64'h2222);
    check("bypass_p2", ReadData2, 64'h2222);
    tick();
    RegWrite = 1'b0;
    #1;
    check("bypass_stored_p1", ReadData1, 64'h2222);
    check("bypass_stored_p2", ReadData2, 64'h2222);

    // 5. Write disabled for 4 edges after a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'hABCD;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd7;
    #1 check("rst2_x7_cleared", ReadData2, 64'h0);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("wr_dis_x3_edge%0d", i), ReadData1, 64'h0);
      tick();
    end
    #1 check("wr_dis_x3_final", ReadData1, 64'h0);

    // 6. Reset asserted alongside a write to X12.
    RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 64'h55AA;
    tick();
    reset = 1'b0; WriteData = 64'h77; ReadRegister1 = 5'd12; ReadRegister2 = 5'd12;
    #1;
    check("rst_mid_p1_stored", ReadData1, 64'h55AA);
    check("rst_mid_p2_stored", ReadData2, 64'h55AA);
    tick();
    reset = 1'b1; RegWrite = 1'b0;
    #1;
    check("rst_mid_x12_cleared", ReadData1, 64'h0);
    check("rst_mid_x12_cleared_p2", ReadData2, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- Architectural register file for the ARM datapath: 32 registers, WIDTH bits each, one synchronous write port and two read ports.
- Sits directly upstream of the bit-sliced 32:1 read multiplexers. The storage rows and write decoder produce the 32 candidate lines per bit that those muxes select from.
- Each read port is built from WIDTH mux32_1 slices. Slice b takes bit b of all 32 rows, and its select is the 5-bit read register number.
- X31 (XZR) always reads zero and ignores writes.

Parameters:
WIDTH  64  data width of each register and of the read/write data buses
ZERO_REG  31  index hardwired to read zero; writes to it are discarded

Ports:
clk  input  1  single system clock; all state updates on its rising edge
reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk
RegWrite  input  1  write enable for the write port
WriteRegister  input  5  destination register index
WriteData  input  WIDTH  data to write
ReadRegister1  input  5  index for read port 1
ReadRegister2  input  5  index for read port 2
ReadData1  output  WIDTH  contents for ReadRegister1
ReadData2  output  WIDTH  contents for ReadRegister2

Behaviour:
- Storage: 32 rows of WIDTH D flip-flops.
  - Row r has its own enable: RegWrite AND (WriteRegister == r) AND (r != ZERO_REG), from a 5:32 decoder.
  - Row ZERO_REG is not stored; it is hardwired to 0.
- Reset:
  - reset == 0 at a rising edge clears every row to 0 on that edge.
  - Reset dominates a simultaneous write: the write is dropped.
  - Reset is synchronous only; asserting it between edges changes nothing until the next edge.
- Write: when reset == 1 and the row enable is 1 at a rising edge, the row takes WriteData. Write latency is 1 cycle.
- Read:
  - Purely combinational, 0-cycle latency from ReadRegisterN and storage to ReadDataN.
  - ReadDataN = row[ReadRegisterN], or 0 when ReadRegisterN == ZERO_REG.
- Write-through bypass: in the same cycle, ReadDataN = WriteData when all of the following hold:
  - RegWrite == 1
  - reset == 1
  - WriteRegister == ReadRegisterN
  - ReadRegisterN != ZERO_REG
  - This lets a value written in cycle k be read in cycle k (pipeline WB/ID overlap).
- Bypass is suppressed while reset == 0, so reads show stored values only.
- Both read ports are independent. Both may address the same register; both may bypass at once.
- Reads never modify state.
- X or Z on an unselected row must not propagate to a read output.
- After reset, all reads return 0 until the first write.
- Out-of-range indices cannot occur (5-bit index, 32 rows).
- No other state, no handshake; a write is accepted every cycle it is requested.

Test Plan:
1. Reset: hold reset=0 for 2 edges with RegWrite=1, WriteRegister=5, WriteData=64'hFFFF. Release reset and sweep ReadRegister1/2 over 0..31 -> all reads 0, and X5 is still 0.
2. Write/read sweep: for i=0..30 write WriteData = i*64'h0101_0101_0101_0101, then read each via both ports -> value matches. Read X30 -> 64'h1E1E_1E1E_1E1E_1E1E.
3. Zero register: write 64'hDEAD_BEEF_0000_0001 to X31, then read ReadRegister1=31 in the same cycle and on the next cycle -> 0 both times, and no other register changes.
4. Bypass: X7 holds 64'h1111. In one cycle set RegWrite=1, WriteRegister=7, WriteData=64'h2222, ReadRegister1=7, ReadRegister2=7 -> both reads 64'h2222 before the edge. With RegWrite=0 the value is identical after the edge.
5. Write disabled: RegWrite=0, WriteRegister=3, WriteData=64'hABCD for 4 edges -> X3 unchanged (0 after reset), and ReadData1 for ReadRegister1=3 never shows 64'hABCD.
6. Reset mid-operation: X12=64'h55AA written. On one edge drive reset=0 together with RegWrite=1, WriteRegister=12, WriteData=64'h77 -> afterwards X12 reads 0. During that cycle ReadRegister1=12 shows 64'h55AA (bypass suppressed).
